// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and the receiver/transmitter
// state encoding, common to uart_rx and uart_tx.
package uart_pkg;

    localparam int FRAME_BITS = 8;
    localparam int BIT_IDX_W  = $clog2(FRAME_BITS);

    typedef logic [FRAME_BITS-1:0] frame_t;
    typedef logic [BIT_IDX_W-1:0]  bit_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam bit_idx_t LAST_BIT = bit_idx_t'(FRAME_BITS - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to RESET_VAL so the output is defined out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), no parity, 1 stop.
// Mid-bit sampling of the synchronized line, level rx_valid with overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rx,
    input  logic   rd,
    output frame_t rx_data,
    output logic   rx_valid,
    output logic   frame_err,
    output logic   overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    bit_idx_t         bit_cnt;
    frame_t           shreg;
    logic             rx_s;
    logic             rx_q;
    logic             fall;
    logic             ack;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    // A start edge is a 1->0 transition of the synchronized line
    assign fall = rx_q & ~rx_s;

    // A read only counts while a byte is actually pending
    assign ack = rd & rx_valid;

    // Receive FSM with baud/bit counters, shift register and output flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_q      <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_q      <= rx_s;
            frame_err <= 1'b0;

            if (ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end

                START: begin
                    if (baud_cnt == HALF_CNT) begin
                        baud_cnt <= '0;
                        // High at mid-start means a glitch, not a frame
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == FULL_CNT) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[FRAME_BITS-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == FULL_CNT) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            // A same-cycle read consumes the old byte
                            if (rx_valid && !rd) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus random frames,
// expected output events queued by the driver and popped by a monitor.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rd       (rd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         valid;
        bit         ovr;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         event_cyc = 0;
    int         lat;
    bit         m_valid = 0;
    bit         m_ovr = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: receiver-visible state after a frame completes
    task automatic expect_frame(input logic [7:0] d, input bit stop_ok,
                                input bit rd_at_done);
        exp_t e;
        if (stop_ok) begin
            m_ovr   = rd_at_done ? 1'b0 : (m_ovr | m_valid);
            m_valid = 1'b1;
            m_data  = d;
            e.ferr  = 1'b0;
        end else begin
            e.ferr  = 1'b1;
        end
        e.data  = m_data;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialize one 10-bit frame; optionally pulse rd at edge start+rd_off
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input bit hold_low, input int rd_off);
        logic [9:0] fr;
        fr = {stop_ok, d, 1'b0};
        @(posedge clk);
        #1;
        start_cyc = cyc;
        for (int c = 0; c < 10 * CPB; c++) begin
            rx = fr[c / CPB];
            rd = (rd_off > 0) && (c + 1 == rd_off);
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
        rx = hold_low ? 1'b0 : 1'b1;
    endtask

    task automatic ack();
        @(posedge clk);
        #1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check("ack_valid", rx_valid, m_valid);
        check("ack_overrun", overrun, m_ovr);
    endtask

    // Monitor: any new output event must match the head of the queue
    initial begin
        bit         pv;
        bit         po;
        bit         pf;
        logic [7:0] pd;
        bit         ev;
        exp_t       e;
        pv = 0;
        po = 0;
        pf = 0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_err) check("ferr_pulse_width", pf, 0);
                ev = frame_err || (rx_valid &&
                     (!pv || rx_data != pd || overrun != po));
                if (ev) begin
                    event_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: ferr=%0b data=%0h valid=%0b ovr=%0b expected none",
                                 frame_err, rx_data, rx_valid, overrun);
                    end else begin
                        e = exp_q.pop_front();
                        check("output_event",
                              {frame_err, rx_valid, overrun, rx_data},
                              {e.ferr, e.valid, e.ovr, e.data});
                    end
                end
            end
            pv = rx_valid;
            po = overrun;
            pf = frame_err;
            pd = rx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("reset_outputs", {rx_data, rx_valid, frame_err, overrun}, 0);
        idle(4);
        rst = 1'b1;
        idle(5);
        check("post_reset_idle", {rx_data, rx_valid, frame_err, overrun}, 0);

        // Clean 0xA5 with latency window
        expect_frame(8'hA5, 1, 0);
        send_frame(8'hA5, 1, 0, 0);
        lat = event_cyc - start_cyc;
        checks++;
        if (lat < 150 || lat > 158) begin
            errors++;
            $display("FAIL latency_a5: got %0d cycles expected 150..158", lat);
        end
        idle(8);
        ack();

        // Short low glitch on an idle line
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(40);
        check("glitch_valid", rx_valid, m_valid);
        check("glitch_data", rx_data, m_data);

        // Bad stop bit, line then held low
        expect_frame(8'h3C, 0, 0);
        send_frame(8'h3C, 0, 1, 0);
        idle(400);
        check("ferr_valid", rx_valid, m_valid);
        check("ferr_data", rx_data, m_data);
        rx = 1'b1;
        idle(20);

        // Two bytes without a read
        expect_frame(8'h11, 1, 0);
        send_frame(8'h11, 1, 0, 0);
        idle(6);
        expect_frame(8'h22, 1, 0);
        send_frame(8'h22, 1, 0, 0);
        idle(6);
        check("overrun_set", {overrun, rx_valid, rx_data}, {1'b1, 1'b1, 8'h22});
        ack();

        // Read on the exact completion cycle of the second byte
        expect_frame(8'hAA, 1, 0);
        send_frame(8'hAA, 1, 0, 0);
        lat = event_cyc - start_cyc;
        idle(6);
        expect_frame(8'h55, 1, 1);
        send_frame(8'h55, 1, 0, lat);
        idle(4);
        check("rd_same_cycle", {overrun, rx_valid, rx_data}, {1'b0, 1'b1, 8'h55});
        ack();

        // Random frames
        for (int i = 0; i < 12; i++) begin
            bit         ok;
            logic [7:0] d;
            ok = ($urandom_range(0, 9) != 0);
            d  = 8'($urandom);
            while (ok && m_valid && d == m_data) d = 8'($urandom);
            expect_frame(d, ok, 0);
            send_frame(d, ok, 0, 0);
            idle(4 + $urandom_range(0, 12));
            if ($urandom_range(0, 1) == 1) ack();
        end

        // Leave a byte pending, then reset during data bit 4 of 0xFF
        expect_frame(8'h5A, 1, 0);
        send_frame(8'h5A, 1, 0, 0);
        idle(6);
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4 * CPB + CPB / 2) @(posedge clk);
        #2;
        rst = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h00;
        #1;
        check("midframe_reset", {rx_data, rx_valid, frame_err, overrun},
              {m_data, m_valid, 1'b0, m_ovr});
        idle(3);
        rst = 1'b1;
        idle(200);
        check("after_reset_idle", {rx_data, rx_valid}, {m_data, m_valid});
        expect_frame(8'h81, 1, 0);
        send_frame(8'h81, 1, 0, 0);
        idle(6);
        check("after_reset_byte", {rx_valid, rx_data}, {1'b1, 8'h81});
        ack();

        idle(20);
        check("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rd  input  1  consumer acknowledge, clears rx_valid and overrun.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid  output  1  level, new byte available until rd.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  sticky, byte completed while rx_valid high and rd low.

Function
REQ-010 SHALL pass rx through two flops (rx_s), both reset to 1; no logic reads raw rx.
REQ-011 SHALL implement states IDLE, START, DATA, STOP; format is 1 start, 8 data LSB first, no parity, 1 stop.
REQ-012 IDLE SHALL move to START on rx_s falling edge (previous 1, current 0) and clear the bit counter.
REQ-013 START SHALL sample rx_s at count CLKS_PER_BIT/2-1: low -> DATA with counter cleared; high -> IDLE (glitch rejected, no output change).
REQ-014 DATA SHALL sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift in LSB first, move to STOP after the 8th sample.
REQ-015 STOP SHALL sample after CLKS_PER_BIT cycles: high -> load rx_data, set rx_valid, go IDLE; low -> pulse frame_err 1 cycle, rx_data/rx_valid unchanged, go IDLE.
REQ-016 Line held low after frame error SHALL NOT restart reception until a new 1->0 edge.
REQ-017 Latency: rx_valid SHALL rise on the cycle after the stop-bit sample (~9.5 bit times plus 2 sync cycles after start edge).
REQ-018 rd with rx_valid high SHALL clear rx_valid and overrun next cycle; rd with rx_valid low SHALL be ignored.
REQ-019 Byte completion with rx_valid high and rd low SHALL overwrite rx_data and set overrun.
REQ-020 Byte completion in the same cycle as rd SHALL leave rx_valid high with new data, overrun not set.
REQ-021 Baud counter width SHALL be $clog2(CLKS_PER_BIT); counter SHALL NOT wrap mid-bit.
REQ-022 Falling edges outside IDLE SHALL be ignored.

Reset
REQ-023 Reset asserted SHALL immediately force IDLE, counters 0, shift register 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, sync flops 1.
REQ-024 Reset mid-frame SHALL discard the partial byte; after deassertion, reception restarts only on a new falling edge.
REQ-025 Reset deassertion SHALL be driven by the team's reset synchronizer output; this block adds no reset synchronization.

Structure
REQ-026 State encoding (IDLE/START/DATA/STOP) and the 8-bit frame width SHALL live in shared package uart_pkg, also used by the future uart_tx.
REQ-027 The two-flop input synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter, here 1).
REQ-028 Remaining logic (FSM, baud counter, bit counter, shift register, output flags) SHALL be in uart_rx.

Verification (CLKS_PER_BIT=16)
REQ-029 Send 0xA5 cleanly -> rx_data=0xA5, rx_valid=1 ~154 cycles after start edge, frame_err never pulses.
REQ-030 5-cycle low glitch on idle line -> returns to IDLE at mid-start sample, rx_valid stays 0, no frame_err.
REQ-031 Send 0x3C with stop bit low -> one-cycle frame_err, rx_valid 0, rx_data unchanged; line held low produces no second frame.
REQ-032 Send 0x11 then 0x22 without rd -> rx_data=0x22, rx_valid=1, overrun=1; rd -> both clear next cycle.
REQ-033 Assert rd on the exact completion cycle of second byte 0x55 -> rx_valid=1, rx_data=0x55, overrun=0.
REQ-034 Assert rst low during DATA bit 4 of 0xFF -> all outputs reset immediately; after release, clean 0x81 received correctly.
